rr_mux_4x1: RTL and testbench
=============================

Name: rr_mux_4x1

Overview:
- 4-input to 1-output streaming multiplexer with round-robin arbitration and valid/ready handshakes on every port.
- Gathers the four lanes produced by the 1:4 demultiplexer path back onto a single registered output stream.
- Tags each output beat with the index of its source lane.
- Gives the combinational demux family a clocked, flow-controlled counterpart.

Parameters:
- WIDTH, 8, data width of each input lane and of the output.
- NUM_IN, 4, number of input lanes. Fixed at 4; the parameter is present for readability only.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  4*WIDTH  packed lane data; lane i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  4  per-lane valid.
- in_ready  output  4  per-lane ready; at most one bit high per cycle.
- out_data  output  WIDTH  registered output data.
- out_sel  output  2  index of the lane that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at clk edge):
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0, state=EMPTY.
  - in_ready is combinational and reads 0 while rst_n=0.
- Output stage: single register slot.
  - Slot is free when state=EMPTY, or when state=FULL and out_valid&out_ready in the current cycle.
- Arbitration (combinational):
  - Among lanes with in_valid=1, grant the first lane found searching upward from rr_ptr, wrapping 3->0.
  - rr_ptr is the lane after the most recently accepted lane.
  - After reset, lane 0 has highest priority.
- in_ready[g]=1 only for the granted lane g, and only when the slot is free. All other in_ready bits are 0.
- Transfer on lane g (in_valid[g]&in_ready[g]) at edge k:
  - out_data=lane g data, out_sel=g, out_valid=1 visible after edge k. Latency is 1 cycle.
  - rr_ptr=(g+1) mod 4.
- FSM states: EMPTY, FULL.
  - EMPTY -> FULL on any accept.
  - FULL -> EMPTY on out_ready with no accept in the same cycle.
  - FULL -> FULL on out_ready with a simultaneous accept. This sustains full throughput, 1 beat per cycle.
  - FULL with out_ready=0: hold out_data, out_sel and out_valid stable; all in_ready=0.
- rr_ptr changes only on an accept. Idle cycles and stalls do not rotate priority.
- No valid lanes: no grant, in_ready=0, state unchanged.
- Handshake rules:
  - in_ready does not combinationally depend on any in_valid bit other than through the arbiter grant.
  - out_valid never drops without out_ready.
- Reset mid-transfer: a pending output beat is discarded; the slot becomes EMPTY and rr_ptr returns to 0.

Optional Feature:
- Macro: RR_MUX_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even parity (XOR reduction) of out_data.
  - Registered alongside out_data; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package rr_mux_pkg:
  - NUM_IN=4, SEL_W=2.
  - State enum {EMPTY, FULL}.
  - Function next_ptr(g) returning (g+1) mod 4.
- Sub-module rr_arbiter_4:
  - Inputs: req[3:0], ptr[1:0], en.
  - Outputs: gnt[3:0] one-hot, gnt_idx[1:0], gnt_vld.
  - Purely combinational.
  - Top level holds the output register, FSM and rr_ptr.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, in_ready=0000, out_sel=0. Release reset -> first accept is lane 0.
- Full contention: in_valid=1111, out_ready=1 constantly, lane i data=8'hA0+i -> out_sel sequence 0,1,2,3,0... with out_data A0,A1,A2,A3, one beat per cycle.
- Sparse request: only lane 2 valid, data 8'h5C -> in_ready=0100. After one cycle: out_valid=1, out_sel=2, out_data=5C. rr_ptr=3, so lane 3 beats lane 0 next.
- Backpressure: out_ready=0 for 5 cycles with a beat held -> out_data and out_sel stable, in_ready=0000. Raise out_ready -> drain plus a new accept in the same cycle.
- Async reset mid-stream: drop rst_n while out_valid=1 -> out_valid falls immediately without waiting for a clk edge. After release, arbitration restarts at lane 0.
- With RR_MUX_PARITY_EN: out_data=8'h07 -> out_parity=1. out_data=8'h03 -> out_parity=0.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants, FSM state type and pointer helper
// for the 4:1 round-robin streaming multiplexer.
package rr_mux_pkg;

    localparam int NUM_IN = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Lane after g, wrapping 3 -> 0 through 2-bit overflow.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
        return g + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational 4-way round-robin arbiter.
// Ports: req[3:0], ptr (highest-priority lane), en -> gnt (one-hot), gnt_idx, gnt_vld.
module rr_arbiter_4
    import rr_mux_pkg::*;
(
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_IN-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    logic [SEL_W-1:0] idx;

    // Walk lanes ptr, ptr+1, ... (mod 4); first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = ptr + SEL_W'(k);
            if (en && !gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_4x1.sv
// rr_mux_4x1: 4:1 round-robin stream mux with a single registered output slot.
// Ports: clk, rst_n (async low), in_data/in_valid/in_ready (4 lanes),
// out_data/out_sel/out_valid/out_ready; out_parity when RR_MUX_PARITY_EN is defined.
module rr_mux_4x1 #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_IN*WIDTH-1:0]       in_data,
    input  logic [NUM_IN-1:0]             in_valid,
    output logic [NUM_IN-1:0]             in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [rr_mux_pkg::SEL_W-1:0]  out_sel,
    output logic                          out_valid,
`ifdef RR_MUX_PARITY_EN
    output logic                          out_parity,
`endif
    input  logic                          out_ready
);
    import rr_mux_pkg::*;

    state_t           state;
    logic [SEL_W-1:0] rr_ptr;
    logic [3:0]       gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             slot_free;
    logic [WIDTH-1:0] gnt_data;

    // Slot accepts when empty, or when the held beat leaves this cycle.
    assign slot_free = (state == EMPTY) ||
                       (state == FULL && out_valid && out_ready);

    rr_arbiter_4 u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .en      (slot_free & rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign in_ready = gnt;
    assign gnt_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
`ifdef RR_MUX_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (gnt_vld) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready && !gnt_vld) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase

            // gnt_vld already implies a free slot, so loading here
            // covers both the fill and the drain-and-refill cases.
            if (gnt_vld) begin
                out_data  <= gnt_data;
                out_sel   <= gnt_idx;
                out_valid <= 1'b1;
                rr_ptr    <= next_ptr(gnt_idx);
`ifdef RR_MUX_PARITY_EN
                out_parity <= ^gnt_data;
`endif
            end else if (state == FULL && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_4x1.sv
// tb_rr_mux_4x1: vector table, hand-written corner sequences and a
// randomized run against a round-robin reference model.
module tb_rr_mux_4x1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
`ifdef RR_MUX_PARITY_EN
    logic        out_parity;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_ptr;
    bit         m_full;
    logic [7:0] m_data;
    int         m_sel;

    typedef struct {
        logic [3:0]  valid;
        logic        ready;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
        logic        exp_vld;
        logic [1:0]  exp_sel;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    rr_mux_4x1 #(.WIDTH(8), .NUM_IN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
`ifdef RR_MUX_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 0;
        m_data = 8'h00;
        m_sel  = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // One cycle checked against the model; inputs driven at posedge+1.
    task automatic rand_cycle();
        int g;
        logic [3:0] er;
        in_valid  = 4'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        in_data   = $urandom;
        g = -1;
        if (!m_full || out_ready)
            for (int k = 0; k < 4; k++)
                if (g < 0 && in_valid[(m_ptr + k) % 4])
                    g = (m_ptr + k) % 4;
        er = (g >= 0) ? 4'(1 << g) : 4'b0000;
        #1 chk("rnd_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (g >= 0) begin
            m_full = 1;
            m_data = in_data[g*8 +: 8];
            m_sel  = g;
            m_ptr  = (g + 1) % 4;
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
        #1;
        chk("rnd_valid", 32'(out_valid), 32'(m_full));
        chk("rnd_data", 32'(out_data), 32'(m_data));
        chk("rnd_sel", 32'(out_sel), 32'(m_sel));
`ifdef RR_MUX_PARITY_EN
        chk("rnd_parity", 32'(out_parity), 32'(^m_data));
`endif
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 32'hA3A2A1A0, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[1]  = '{4'b1111, 1'b1, 32'hA3A2A1A0, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[2]  = '{4'b1111, 1'b1, 32'hA3A2A1A0, 4'b0100, 1'b1, 2'd2, 8'hA2};
        tbl[3]  = '{4'b1111, 1'b1, 32'hA3A2A1A0, 4'b1000, 1'b1, 2'd3, 8'hA3};
        tbl[4]  = '{4'b1111, 1'b1, 32'hA3A2A1A0, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[5]  = '{4'b0100, 1'b1, 32'h005C0000, 4'b0100, 1'b1, 2'd2, 8'h5C};
        tbl[6]  = '{4'b1001, 1'b0, 32'h33000011, 4'b0000, 1'b1, 2'd2, 8'h5C};
        tbl[7]  = '{4'b1001, 1'b0, 32'h33000011, 4'b0000, 1'b1, 2'd2, 8'h5C};
        tbl[8]  = '{4'b1001, 1'b1, 32'h33000011, 4'b1000, 1'b1, 2'd3, 8'h33};
        tbl[9]  = '{4'b0000, 1'b1, 32'h33000011, 4'b0000, 1'b0, 2'd3, 8'h33};
        tbl[10] = '{4'b0000, 1'b0, 32'h33000011, 4'b0000, 1'b0, 2'd3, 8'h33};
        tbl[11] = '{4'b1001, 1'b0, 32'h33000011, 4'b0001, 1'b1, 2'd0, 8'h11};

        // Reset with every lane requesting
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 32'hA3A2A1A0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_sel", 32'(out_sel), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 12; i++) begin
            in_valid  = tbl[i].valid;
            out_ready = tbl[i].ready;
            in_data   = tbl[i].data;
            #1 chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d_sel", i), 32'(out_sel), 32'(tbl[i].exp_sel));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp_data));
        end

        // Backpressure: beat 0x11 from lane 0 held, rr_ptr now 1
        in_valid  = 4'b1111;
        in_data   = 32'hA3A2A1A0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bp_data", 32'(out_data), 32'h11);
            chk("bp_sel", 32'(out_sel), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'b0010);
        @(posedge clk);
        #1;
        chk("bp_release_data", 32'(out_data), 32'hA1);
        chk("bp_release_sel", 32'(out_sel), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset in the middle of a cycle with a beat held
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("arst_restart_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("arst_restart_sel", 32'(out_sel), 32'd0);
        chk("arst_restart_data", 32'(out_data), 32'hA0);

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) rand_cycle();

`ifdef RR_MUX_PARITY_EN
        do_reset();
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        in_data   = 32'h00000007;
        @(posedge clk);
        #1 chk("parity_07", 32'(out_parity), 32'd1);
        in_data = 32'h00000003;
        @(posedge clk);
        #1 chk("parity_03", 32'(out_parity), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
